// File: rtl/spi_pkg.sv
// Shared definitions for the SPI register bank: FSM encoding, status width,
// and the bit-counter width helper.
package spi_pkg;

    typedef enum logic [1:0] {
        ST_SKIP = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    localparam int STATUS_W = 8;

    // The counter must be able to hold DW+1 so that overlong frames stay distinguishable.
    function automatic int cnt_width(input int dw);
        return $clog2(dw + 2);
    endfunction

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchroniser for one asynchronous SPI pin, with rise/fall detection
// taken from the two oldest stages.
module spi_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    // Stage 0 is the newest sample, stage STAGES-1 the oldest.
    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], din};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = sync_q[STAGES-2] & ~sync_q[STAGES-1];
    assign fall  = ~sync_q[STAGES-2] & sync_q[STAGES-1];

endmodule

// File: rtl/spi_regbank.sv
// Generic bank of NREGS double-buffered registers written and read back by the
// AVR over a CS-framed SPI link (register number while CS high, data while CS low).
module spi_regbank
    import spi_pkg::*;
#(
    parameter int         NREGS       = 8,
    parameter int         DW          = 8,
    parameter logic [7:0] BASE_ADDR   = 8'h50,
    parameter int         SYNC_STAGES = 2,
    parameter bit         LSB_FIRST   = 1'b1
) (
    input  logic                fclk,
    input  logic                rst,
    input  logic                spics_n,
    input  logic                spick,
    input  logic                spido,
    output logic                spidi,
    input  logic [7:0]          status_in,
    input  logic [NREGS*DW-1:0] rd_data,
    output logic [NREGS*DW-1:0] wr_data,
    output logic [NREGS-1:0]    wr_stb,
    output logic [NREGS-1:0]    rd_stb,
    output logic                frame_err
);

    localparam int CW = cnt_width(DW);
    localparam int IW = (NREGS > 1) ? $clog2(NREGS) : 1;

    logic cs_level, cs_rise, cs_fall;
    logic sck_level, sck_rise, sck_fall;
    logic sdo_level, sdo_rise, sdo_fall;
    logic unused_sync;

    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk(fclk), .rst(rst), .din(spics_n),
        .level(cs_level), .rise(cs_rise), .fall(cs_fall)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
        .clk(fclk), .rst(rst), .din(spick),
        .level(sck_level), .rise(sck_rise), .fall(sck_fall)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sdo (
        .clk(fclk), .rst(rst), .din(spido),
        .level(sdo_level), .rise(sdo_rise), .fall(sdo_fall)
    );

    assign unused_sync = ^{sck_level, sck_fall, sdo_rise, sdo_fall};

    state_t              state_q, state_d;
    logic [7:0]          regnum_q, regnum_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [DW-1:0]       in_sh_q, in_sh_d;
    logic [DW-1:0]       out_sh_q, out_sh_d;
    logic [NREGS*DW-1:0] wr_data_q, wr_data_d;
    logic [NREGS-1:0]    wr_stb_q, wr_stb_d;
    logic [NREGS-1:0]    rd_stb_q, rd_stb_d;
    logic                frame_err_q, frame_err_d;

    logic [8:0]    diff;
    logic          hit;
    logic [IW-1:0] idx;
    logic [DW-1:0] rd_sel;
    logic [DW-1:0] status_ext;
    logic [DW-1:0] out_shifted;

    // Nine-bit subtraction makes addresses below BASE_ADDR land far above NREGS.
    always_comb begin
        diff       = {1'b0, regnum_q} - {1'b0, BASE_ADDR};
        hit        = (diff < 9'(NREGS));
        idx        = diff[IW-1:0];
        rd_sel     = '1;
        for (int i = 0; i < NREGS; i++) begin
            if (hit && (idx == IW'(i))) begin
                rd_sel = rd_data[i*DW +: DW];
            end
        end
        status_ext = '0;
        status_ext[STATUS_W-1:0] = status_in;
        out_shifted = LSB_FIRST ? {1'b0, out_sh_q[DW-1:1]} : {out_sh_q[DW-2:0], 1'b0};
    end

    always_comb begin
        state_d     = state_q;
        regnum_d    = regnum_q;
        cnt_d       = cnt_q;
        in_sh_d     = in_sh_q;
        out_sh_d    = out_sh_q;
        wr_data_d   = wr_data_q;
        wr_stb_d    = '0;
        rd_stb_d    = '0;
        frame_err_d = 1'b0;
        case (state_q)
            ST_SKIP: begin
                if (cs_level) begin
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (cs_fall) begin
                    state_d  = ST_DATA;
                    out_sh_d = rd_sel;
                    cnt_d    = '0;
                    in_sh_d  = '0;
                    for (int i = 0; i < NREGS; i++) begin
                        if (hit && (idx == IW'(i))) begin
                            rd_stb_d[i] = 1'b1;
                        end
                    end
                end else if (sck_rise) begin
                    regnum_d = LSB_FIRST ? {sdo_level, regnum_q[7:1]} : {regnum_q[6:0], sdo_level};
                    out_sh_d = out_shifted;
                end
            end
            ST_DATA: begin
                // A CS edge in the same cycle as an SCK edge takes priority.
                if (cs_rise) begin
                    state_d  = ST_ADDR;
                    out_sh_d = status_ext;
                    regnum_d = '0;
                    if (hit && (cnt_q == CW'(DW))) begin
                        for (int i = 0; i < NREGS; i++) begin
                            if (idx == IW'(i)) begin
                                wr_data_d[i*DW +: DW] = in_sh_q;
                                wr_stb_d[i]           = 1'b1;
                            end
                        end
                    end else if (hit && (cnt_q != '0)) begin
                        frame_err_d = 1'b1;
                    end
                end else if (sck_rise) begin
                    in_sh_d  = LSB_FIRST ? {sdo_level, in_sh_q[DW-1:1]} : {in_sh_q[DW-2:0], sdo_level};
                    out_sh_d = out_shifted;
                    if (cnt_q != CW'(DW + 1)) begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = ST_SKIP;
        endcase
    end

    always_ff @(posedge fclk) begin
        if (rst) begin
            state_q     <= ST_SKIP;
            regnum_q    <= '0;
            cnt_q       <= '0;
            in_sh_q     <= '0;
            out_sh_q    <= '0;
            wr_data_q   <= '0;
            wr_stb_q    <= '0;
            rd_stb_q    <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            regnum_q    <= regnum_d;
            cnt_q       <= cnt_d;
            in_sh_q     <= in_sh_d;
            out_sh_q    <= out_sh_d;
            wr_data_q   <= wr_data_d;
            wr_stb_q    <= wr_stb_d;
            rd_stb_q    <= rd_stb_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign spidi     = LSB_FIRST ? out_sh_q[0] : out_sh_q[DW-1];
    assign wr_data   = wr_data_q;
    assign wr_stb    = wr_stb_q;
    assign rd_stb    = rd_stb_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_regbank.sv
// Bench for spi_regbank: a default instance (8x8, LSB first) and a 3x16 MSB-first
// instance, each driven by its own bit-banged AVR master.
module tb_spi_regbank;

    typedef struct {
        logic [7:0]  addr;
        int          nbits;
        logic [15:0] data;
        int          exp_wr;
        int          exp_rd;
        bit          exp_err;
        logic [15:0] exp_rx;
        bit          chk_st;
        logic [7:0]  exp_st;
    } vec_t;

    logic        fclk = 1'b0;
    logic        rst  = 1'b1;
    logic [1:0]  cs_n = 2'b11;
    logic [1:0]  sck  = 2'b00;
    logic [1:0]  sdo  = 2'b00;

    logic [7:0]  status_a = 8'h81;
    logic [63:0] rd_data_a;
    logic [63:0] wr_data_a;
    logic [7:0]  wr_stb_a, rd_stb_a;
    logic        err_a, spidi_a;

    logic [7:0]  status_b = 8'hC3;
    logic [47:0] rd_data_b = '0;
    logic [47:0] wr_data_b;
    logic [2:0]  wr_stb_b, rd_stb_b;
    logic        err_b, spidi_b;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int cs_rise_cyc = 0;
    int last_wr_cyc = 0;
    int multi_hot   = 0;
    int wr_cnt_a[8], rd_cnt_a[8], err_cnt_a;
    int wr_cnt_b[3], rd_cnt_b[3], err_cnt_b;
    logic [7:0] model_a[8];

    spi_regbank u_dut_a (
        .fclk(fclk), .rst(rst), .spics_n(cs_n[0]), .spick(sck[0]), .spido(sdo[0]),
        .spidi(spidi_a), .status_in(status_a), .rd_data(rd_data_a),
        .wr_data(wr_data_a), .wr_stb(wr_stb_a), .rd_stb(rd_stb_a), .frame_err(err_a)
    );

    spi_regbank #(.NREGS(3), .DW(16), .BASE_ADDR(8'h50), .SYNC_STAGES(2), .LSB_FIRST(1'b0)) u_dut_b (
        .fclk(fclk), .rst(rst), .spics_n(cs_n[1]), .spick(sck[1]), .spido(sdo[1]),
        .spidi(spidi_b), .status_in(status_b), .rd_data(rd_data_b),
        .wr_data(wr_data_b), .wr_stb(wr_stb_b), .rd_stb(rd_stb_b), .frame_err(err_b)
    );

    always #5 fclk = ~fclk;

    always @(posedge fclk) cyc <= cyc + 1;

    // Pulse monitor, sampled away from the active edge.
    always @(negedge fclk) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++) begin
                if (wr_stb_a[i]) wr_cnt_a[i]++;
                if (rd_stb_a[i]) rd_cnt_a[i]++;
            end
            for (int i = 0; i < 3; i++) begin
                if (wr_stb_b[i]) wr_cnt_b[i]++;
                if (rd_stb_b[i]) rd_cnt_b[i]++;
            end
            if (err_a) err_cnt_a++;
            if (err_b) err_cnt_b++;
            if (wr_stb_a != 0) last_wr_cyc = cyc;
            if ($countones(wr_stb_a) > 1 || $countones(rd_stb_a) > 1 ||
                $countones(wr_stb_b) > 1 || $countones(rd_stb_b) > 1) multi_hot++;
        end
    end

    initial begin
        #800000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Bits in wire order: position k is the k-th bit on the line.
    function automatic logic [31:0] order_bits(input logic [15:0] v, input int width,
                                               input int n, input bit lsb);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < n; k++) begin
            if (k < width) r[k] = lsb ? v[k] : v[width-1-k];
        end
        return r;
    endfunction

    task automatic half();
        repeat (4) @(negedge fclk);
    endtask

    task automatic xfer(input int sel, input int n, input logic [31:0] tx, output logic [31:0] rx);
        rx = '0;
        for (int k = 0; k < n; k++) begin
            sdo[sel] = tx[k];
            half();
            rx[k] = (sel == 1) ? spidi_b : spidi_a;
            sck[sel] = 1'b1;
            half();
            sck[sel] = 1'b0;
        end
        sdo[sel] = 1'b0;
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 8; i++) begin wr_cnt_a[i] = 0; rd_cnt_a[i] = 0; end
        for (int i = 0; i < 3; i++) begin wr_cnt_b[i] = 0; rd_cnt_b[i] = 0; end
        err_cnt_a = 0;
        err_cnt_b = 0;
    endtask

    task automatic frame(input int sel, input logic [7:0] addr, input int n, input logic [15:0] data,
                         output logic [31:0] st_rx, output logic [31:0] d_rx);
        int w;
        bit lsb;
        w   = (sel == 1) ? 16 : 8;
        lsb = (sel == 0);
        xfer(sel, 8, order_bits({8'h00, addr}, 8, 8, lsb), st_rx);
        half();
        cs_n[sel] = 1'b0;
        half();
        half();
        xfer(sel, n, order_bits(data, w, n, lsb), d_rx);
        half();
        cs_n[sel] = 1'b1;
        cs_rise_cyc = cyc;
        half();
        half();
    endtask

    task automatic apply_a(input vec_t v, input string tag);
        logic [31:0] st, rx;
        logic [63:0] exp_wd;
        logic [7:0]  wr_hit, rd_hit, exp_wh, exp_rh;
        int wr_sum, rd_sum;
        clear_counts();
        frame(0, v.addr, v.nbits, v.data, st, rx);
        if (v.chk_st) check($sformatf("%s status", tag), st, order_bits({8'h00, v.exp_st}, 8, 8, 1));
        if (v.nbits > 0) check($sformatf("%s miso", tag), rx, order_bits(v.exp_rx, 8, v.nbits, 1));
        if (v.exp_wr >= 0) model_a[v.exp_wr] = v.data[7:0];
        for (int i = 0; i < 8; i++) exp_wd[i*8 +: 8] = model_a[i];
        check($sformatf("%s wr_data", tag), wr_data_a, exp_wd);
        wr_sum = 0;
        rd_sum = 0;
        for (int i = 0; i < 8; i++) begin
            wr_hit[i] = (wr_cnt_a[i] == 1);
            rd_hit[i] = (rd_cnt_a[i] == 1);
            wr_sum += wr_cnt_a[i];
            rd_sum += rd_cnt_a[i];
        end
        exp_wh = (v.exp_wr >= 0) ? (8'h01 << v.exp_wr) : 8'h00;
        exp_rh = (v.exp_rd >= 0) ? (8'h01 << v.exp_rd) : 8'h00;
        check($sformatf("%s wr_stb", tag), {wr_sum[7:0], wr_hit}, {((v.exp_wr >= 0) ? 8'd1 : 8'd0), exp_wh});
        check($sformatf("%s rd_stb", tag), {rd_sum[7:0], rd_hit}, {((v.exp_rd >= 0) ? 8'd1 : 8'd0), exp_rh});
        check($sformatf("%s frame_err", tag), err_cnt_a, v.exp_err ? 1 : 0);
        if (v.exp_wr >= 0) check($sformatf("%s stb latency", tag), last_wr_cyc - cs_rise_cyc, 2);
    endtask

    initial begin
        vec_t tbl[9];
        vec_t v;
        logic [31:0] st, rx;
        int nb_choice[9] = '{0, 8, 8, 8, 8, 1, 7, 9, 11};

        for (int i = 0; i < 8; i++) begin
            rd_data_a[i*8 +: 8] = 8'h30 + 8'(i);
            model_a[i] = 8'h00;
        end
        rd_data_a[5*8 +: 8] = 8'h3C;

        //          addr   n   data      wr  rd  err rx      st? st
        tbl[0] = '{8'h52, 8, 16'h00A5,  2,  2, 0, 16'h32, 1, 8'h00};
        tbl[1] = '{8'h55, 8, 16'h005A,  5,  5, 0, 16'h3C, 1, 8'h81};
        tbl[2] = '{8'h52, 5, 16'h001F, -1,  2, 1, 16'h32, 1, 8'h81};
        tbl[3] = '{8'h52, 9, 16'h01C3, -1,  2, 1, 16'h32, 1, 8'h81};
        tbl[4] = '{8'h4F, 8, 16'h0077, -1, -1, 0, 16'hFF, 1, 8'h81};
        tbl[5] = '{8'h58, 8, 16'h0077, -1, -1, 0, 16'hFF, 1, 8'h81};
        tbl[6] = '{8'h50, 0, 16'h0000, -1,  0, 0, 16'h00, 1, 8'h81};
        tbl[7] = '{8'h57, 8, 16'h0096,  7,  7, 0, 16'h37, 1, 8'h81};
        tbl[8] = '{8'h50, 8, 16'h0011,  0,  0, 0, 16'h30, 1, 8'h81};

        clear_counts();
        repeat (3) @(negedge fclk);
        check("reset spidi", spidi_a, 1'b0);
        rst = 1'b0;
        @(negedge fclk);
        check("reset wr_data_a", wr_data_a, 64'h0);
        check("reset wr_data_b", wr_data_b, 64'h0);
        check("reset strobes", {wr_stb_a, rd_stb_a, wr_stb_b, rd_stb_b}, 64'h0);
        check("reset frame_err", {err_a, err_b}, 64'h0);
        half();

        for (int i = 0; i < 9; i++) apply_a(tbl[i], $sformatf("vec%0d", i));

        // Reset in the middle of a write to 0x51: the tail of that frame must be ignored.
        clear_counts();
        xfer(0, 8, order_bits(16'h0051, 8, 8, 1), st);
        half();
        cs_n[0] = 1'b0;
        half();
        half();
        xfer(0, 4, 32'h5, rx);
        rst = 1'b1;
        repeat (3) @(negedge fclk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) model_a[i] = 8'h00;
        clear_counts();
        xfer(0, 4, 32'hA, rx);
        half();
        cs_n[0] = 1'b1;
        half();
        half();
        check("midreset wr_data", wr_data_a, 64'h0);
        check("midreset wr_stb", wr_cnt_a[1] + wr_cnt_a[0], 0);
        check("midreset frame_err", err_cnt_a, 0);
        v = '{8'h51, 8, 16'h00C6, 1, 1, 0, 16'h31, 0, 8'h00};
        apply_a(v, "after_reset");

        // Randomised frames against a rule-level model.
        for (int t = 0; t < 40; t++) begin
            int idx;
            bit hit;
            for (int i = 0; i < 8; i++) rd_data_a[i*8 +: 8] = 8'($urandom);
            v.addr  = 8'h4C + 8'($urandom_range(0, 15));
            v.nbits = nb_choice[$urandom_range(0, 8)];
            v.data  = 16'($urandom);
            hit     = (v.addr >= 8'h50) && (v.addr < 8'h58);
            idx     = int'(v.addr) - 'h50;
            v.exp_wr  = (hit && v.nbits == 8) ? idx : -1;
            v.exp_rd  = hit ? idx : -1;
            v.exp_err = hit && (v.nbits != 0) && (v.nbits != 8);
            v.exp_rx  = hit ? {8'h00, rd_data_a[idx*8 +: 8]} : 16'h00FF;
            v.chk_st  = 1'b1;
            v.exp_st  = 8'h81;
            apply_a(v, $sformatf("rnd%0d", t));
        end

        // Wide, MSB-first instance.
        clear_counts();
        frame(1, 8'h51, 16, 16'hBEEF, st, rx);
        check("b write data", wr_data_b, {16'h0000, 16'hBEEF, 16'h0000});
        check("b write stb", {wr_cnt_b[2], wr_cnt_b[1], wr_cnt_b[0]}, {32'd0, 32'd1, 32'd0});
        check("b write err", err_cnt_b, 0);

        rd_data_b[16 +: 16] = 16'h1234;
        clear_counts();
        frame(1, 8'h51, 16, 16'hCAFE, st, rx);
        check("b status pad", st, 32'h0);
        check("b readback", rx, order_bits(16'h1234, 16, 16, 0));
        check("b rd_stb", {rd_cnt_b[2], rd_cnt_b[1], rd_cnt_b[0]}, {32'd0, 32'd1, 32'd0});
        check("b overwrite", wr_data_b[31:16], 16'hCAFE);

        clear_counts();
        frame(1, 8'h53, 16, 16'h0F0F, st, rx);
        check("b miss miso", rx, 32'h0000FFFF);
        check("b miss strobes", wr_cnt_b[0] + wr_cnt_b[1] + wr_cnt_b[2] + rd_cnt_b[0] + rd_cnt_b[1] + rd_cnt_b[2] + err_cnt_b, 0);
        check("b miss data", wr_data_b, {16'h0000, 16'hCAFE, 16'h0000});

        check("one-hot strobes", multi_hot, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
